// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - prescaled LED pattern sequencer with GPIO counter tap
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   en    in   prescaler enable; count holds when low
//   div   in   prescaler terminal count; step period = div+1 cycles
//   mode  in   pattern mode captured on load: 0 ROTL, 1 ROTR, 2 BOUNCE, 3 COUNT
//   load  in   one-cycle strobe: capture mode, reseed pattern, restart prescaler
//   led   out  pattern register
//   gpio  out  low GPIO_W bits of the prescaler count
//   step  out  registered one-cycle advance strobe
//   dir   out  bounce direction: 0 = toward MSB, 1 = toward LSB

module led_sequencer #(
    parameter int LED_W  = 8,
    parameter int DIV_W  = 27,
    parameter int GPIO_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        mode,
    input  logic              load,
    output logic [LED_W-1:0]  led,
    output logic [GPIO_W-1:0] gpio,
    output logic              step,
    output logic              dir
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    mode_e              mode_q;
    logic [DIV_W-1:0]   cnt_q;
    logic               step_q;
    logic [LED_W-1:0]   led_q;
    logic               dir_q;

    logic [LED_W-1:0]   led_d;
    logic               dir_d;

    // Next pattern for one advance; only applied on edges where step_q is set.
    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        unique case (mode_q)
            MODE_ROTL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_ROTR: led_d = {led_q[0], led_q[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (led_q == '0) begin
                    // Pattern lost its bit: restart from the LSB end.
                    led_d = LED_W'(1);
                    dir_d = 1'b0;
                end else if (!dir_q) begin
                    // Turn around in the same edge so the end bit shows for one step only.
                    if (led_q[LED_W-1]) begin
                        dir_d = 1'b1;
                        led_d = led_q >> 1;
                    end else begin
                        led_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        dir_d = 1'b0;
                        led_d = led_q << 1;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
            end
            MODE_COUNT: led_d = led_q + LED_W'(1);
            default: led_d = led_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_ROTL;
            cnt_q  <= '0;
            step_q <= 1'b0;
            led_q  <= LED_W'(1);
            dir_q  <= 1'b0;
        end else if (load) begin
            // Any step pending on this edge is dropped along with the old pattern.
            mode_q <= mode_e'(mode);
            cnt_q  <= '0;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            led_q  <= (mode_e'(mode) == MODE_COUNT) ? '0 : LED_W'(1);
        end else begin
            if (en) begin
                // Equality only: a div lowered below cnt waits for the counter to wrap.
                if (cnt_q == div) begin
                    cnt_q  <= '0;
                    step_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + DIV_W'(1);
                    step_q <= 1'b0;
                end
            end else begin
                step_q <= 1'b0;
            end
            // A registered step advances even if en has since dropped.
            if (step_q) begin
                led_q <= led_d;
                dir_q <= dir_d;
            end
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign gpio = cnt_q[GPIO_W-1:0];

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized and directed bench for led_sequencer

module tb_led_sequencer;

    localparam int LED_W  = 8;
    localparam int DIV_W  = 4;
    localparam int GPIO_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [1:0]        mode = '0;
    logic              load = 1'b0;
    logic [LED_W-1:0]  led;
    logic [GPIO_W-1:0] gpio;
    logic              step;
    logic              dir;

    led_sequencer #(.LED_W(LED_W), .DIV_W(DIV_W), .GPIO_W(GPIO_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .mode (mode),
        .load (load),
        .led  (led),
        .gpio (gpio),
        .step (step),
        .dir  (dir)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: a lit position for the one-hot modes, a plain number for COUNT.
    int m_cnt  = 0;
    int m_step = 0;
    int m_pos  = 0;
    int m_cval = 0;
    int m_mode = 0;
    int m_dir  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_led();
        if (m_mode == 3) return m_cval;
        return 1 << m_pos;
    endfunction

    // One clock edge: predict from the inputs, clock the DUT, then compare.
    task automatic tick();
        int n_cnt, n_step, n_pos, n_cval, n_mode, n_dir;
        n_cnt = m_cnt; n_step = m_step; n_pos = m_pos;
        n_cval = m_cval; n_mode = m_mode; n_dir = m_dir;
        if (rst) begin
            n_cnt = 0; n_step = 0; n_pos = 0; n_cval = 0; n_mode = 0; n_dir = 0;
        end else if (load) begin
            n_mode = int'(mode); n_cnt = 0; n_step = 0; n_dir = 0; n_pos = 0; n_cval = 0;
        end else begin
            if (en) begin
                if (m_cnt == int'(div)) begin
                    n_cnt = 0; n_step = 1;
                end else begin
                    n_cnt = (m_cnt + 1) % (1 << DIV_W); n_step = 0;
                end
            end else begin
                n_step = 0;
            end
            if (m_step == 1) begin
                case (m_mode)
                    0: n_pos = (m_pos + 1) % LED_W;
                    1: n_pos = (m_pos + LED_W - 1) % LED_W;
                    2: begin
                        if (m_dir == 0) begin
                            if (m_pos == LED_W - 1) begin n_dir = 1; n_pos = m_pos - 1; end
                            else n_pos = m_pos + 1;
                        end else begin
                            if (m_pos == 0) begin n_dir = 0; n_pos = 1; end
                            else n_pos = m_pos - 1;
                        end
                    end
                    default: n_cval = (m_cval + 1) % (1 << LED_W);
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_step = n_step; m_pos = n_pos;
        m_cval = n_cval; m_mode = n_mode; m_dir = n_dir;
        chk("led", 32'(led), 32'(exp_led()));
        chk("step", 32'(step), 32'(m_step));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("gpio", 32'(gpio), 32'(m_cnt % (1 << GPIO_W)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [1:0] m, input logic [DIV_W-1:0] d);
        mode = m;
        div  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Edges until step is seen; an expired budget returns the budget and fails the check.
    task automatic edges_to_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 40);
    endtask

    initial begin
        int n;

        rst = 1'b1;
        run(2);
        chk("rst_led", 32'(led), 32'h01);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_gpio", 32'(gpio), 32'h0);

        // Default ROTL, div=3: first step four edges after release.
        rst = 1'b0;
        en  = 1'b1;
        div = 4'd3;
        edges_to_step(n);
        chk("first_step", 32'(n), 32'd4);
        run(40);

        do_load(2'd1, 4'd0);   // ROTR every cycle
        run(20);
        do_load(2'd2, 4'd1);   // BOUNCE
        run(40);
        do_load(2'd3, 4'd0);   // COUNT through 8-bit wrap
        run(260);

        // en freeze at cnt=2, div=3.
        do_load(2'd0, 4'd3);
        run(2);
        chk("frz_gpio0", 32'(gpio), 32'd2);
        en = 1'b0;
        run(10);
        chk("frz_gpio1", 32'(gpio), 32'd2);
        en = 1'b1;
        edges_to_step(n);
        chk("frz_resume", 32'(n), 32'd2);

        // load on an edge where step is high, ROTL with led=08.
        do_load(2'd0, 4'd0);
        run(4);
        chk("ld_pre_led", 32'(led), 32'h08);
        chk("ld_pre_step", 32'(step), 32'h1);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("ld_led", 32'(led), 32'h01);
        chk("ld_step", 32'(step), 32'h0);

        // Reset in BOUNCE while heading toward LSB.
        do_load(2'd2, 4'd0);
        n = 0;
        while (dir !== 1'b1 && n < 30) begin tick(); n++; end
        chk("bnc_dir1", 32'(dir), 32'h1);
        run(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_led", 32'(led), 32'h01);
        chk("mid_rst_dir", 32'(dir), 32'h0);
        chk("mid_rst_gpio", 32'(gpio), 32'h0);

        // div lowered below cnt: counter must wrap through 2^DIV_W.
        do_load(2'd0, 4'd10);
        run(5);
        chk("wrap_gpio", 32'(gpio), 32'd5);
        div = 4'd2;
        edges_to_step(n);
        chk("wrap_edges", 32'(n), 32'd14);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom % 8) != 0;
            rst  = ($urandom % 400) == 0;
            load = ($urandom % 50) == 0;
            if (load) begin
                mode = 2'($urandom % 4);
                div  = 4'($urandom % 5);
            end else if (($urandom % 200) == 0) begin
                div = 4'($urandom % 16);
            end
            tick();
        end
        rst  = 1'b0;
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
